// File: rtl/max_unpool_scatter.sv
// Max-unpooling scatter: queues 2-bit argmax lane indices and places each later pooled value into its lane.
// Optional MAX_UNPOOL_STATS_EN adds an accepted-beat counter and a sticky underrun flag.
module max_unpool_scatter #(
  parameter int unsigned LANE_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idx_valid,
  input  logic [1:0]            idx_in,
  output logic                  idx_ready,
  input  logic                  val_valid,
  input  logic [LANE_W-1:0]     val_in,
  output logic                  val_ready,
  output logic                  out_valid,
  output logic [4*LANE_W-1:0]   out_data,
  input  logic                  out_ready,
  output logic [ADDR_W:0]       idx_count
`ifdef MAX_UNPOOL_STATS_EN
  ,
  output logic [31:0]           out_count,
  output logic                  underrun
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned OUT_W = 4 * LANE_W;

  logic [1:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_c;
  logic              pop_c;
  logic              free_c;
  logic [OUT_W-1:0]  scatter_c;

  // Handshakes; readiness is derived from registered occupancy only, so no bypass path exists.
  always_comb begin
    free_c    = !out_valid || out_ready;
    idx_ready = !rst && (idx_count != CNT_W'(DEPTH));
    val_ready = (idx_count != '0) && free_c;
    push_c    = idx_valid && idx_ready;
    pop_c     = val_valid && val_ready;
  end

  // Place the value in the lane named by the oldest index; all other lanes zero.
  always_comb begin
    scatter_c = '0;
    for (int l = 0; l < 4; l++) begin
      if (mem[rd_ptr] == 2'(l)) scatter_c[l*LANE_W +: LANE_W] = val_in;
    end
  end

  // Index storage; contents need no reset since occupancy governs validity.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= idx_in;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      idx_count <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_c, pop_c})
        2'b10:   idx_count <= idx_count + CNT_W'(1);
        2'b01:   idx_count <= idx_count - CNT_W'(1);
        default: idx_count <= idx_count;
      endcase
    end
  end

  // Output register: loads on pop, drops valid when consumed, holds data otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop_c) begin
      out_valid <= 1'b1;
      out_data  <= scatter_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MAX_UNPOOL_STATS_EN
  // Accepted-beat counter (free-running wrap) and sticky underrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_count <= '0;
      underrun  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_count <= out_count + 32'd1;
      if (val_valid && (idx_count == '0)) underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_max_unpool_scatter.sv
// Directed self-checking bench for max_unpool_scatter; optional stats checked when MAX_UNPOOL_STATS_EN is defined.
module tb_max_unpool_scatter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         idx_valid = 1'b0;
  logic [1:0]   idx_in = 2'd0;
  logic         idx_ready;
  logic         val_valid = 1'b0;
  logic [31:0]  val_in = 32'd0;
  logic         val_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready = 1'b1;
  logic [4:0]   idx_count;
`ifdef MAX_UNPOOL_STATS_EN
  logic [31:0]  out_count;
  logic         underrun;
`endif

  int passed = 0;
  int total  = 0;
  int q[$];
  logic [127:0] exp_data;

  always #5 clk = ~clk;

  max_unpool_scatter #(.LANE_W(32), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .idx_valid(idx_valid), .idx_in(idx_in), .idx_ready(idx_ready),
    .val_valid(val_valid), .val_in(val_in), .val_ready(val_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .idx_count(idx_count)
`ifdef MAX_UNPOOL_STATS_EN
    , .out_count(out_count), .underrun(underrun)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [127:0] lane(input int l, input logic [31:0] v);
    logic [127:0] r;
    r = '0;
    r[l*32 +: 32] = v;
    return r;
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_count", 128'(idx_count), 128'd0);
    rst = 1'b0;
    settle();
    chk("rel_idx_ready", 128'(idx_ready), 128'd1);
    chk("rel_val_ready", 128'(val_ready), 128'd0);

    // Single push of lane 2 then negative value
    idx_valid = 1'b1; idx_in = 2'd2;
    val_valid = 1'b1; val_in = 32'h1234_5678;
    settle();
    chk("nobypass_val_ready", 128'(val_ready), 128'd0);
    val_valid = 1'b0;
    tick();
    idx_valid = 1'b0;
    chk("t2_count1", 128'(idx_count), 128'd1);
    val_valid = 1'b1; val_in = 32'hFFFF_FFF6;
    settle();
    chk("t2_val_ready", 128'(val_ready), 128'd1);
    tick();
    val_valid = 1'b0;
    chk("t2_out_valid", 128'(out_valid), 128'd1);
    chk("t2_out_data", out_data, 128'h0000_0000_FFFF_FFF6_0000_0000_0000_0000);
    chk("t2_count0", 128'(idx_count), 128'd0);
    tick();
    chk("t2_drop_valid", 128'(out_valid), 128'd0);
    chk("t2_hold_data", out_data, 128'h0000_0000_FFFF_FFF6_0000_0000_0000_0000);

    // Fill to DEPTH, stall the 17th, drain at full rate
    for (int i = 0; i < 16; i++) begin
      idx_valid = 1'b1; idx_in = 2'(i % 4);
      tick();
    end
    idx_in = 2'd3;
    settle();
    chk("t3_full_count", 128'(idx_count), 128'd16);
    chk("t3_full_idx_ready", 128'(idx_ready), 128'd0);
    tick();
    chk("t3_stall_count", 128'(idx_count), 128'd16);
    val_valid = 1'b1; val_in = 32'd1;
    settle();
    chk("t3_pop_full_idx_ready", 128'(idx_ready), 128'd0);
    chk("t3_pop_full_val_ready", 128'(val_ready), 128'd1);
    idx_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      val_in = 32'(i + 1);
      tick();
      chk("t3_beat_valid", 128'(out_valid), 128'd1);
      chk("t3_beat_data", out_data, lane(i % 4, 32'(i + 1)));
    end
    val_valid = 1'b0;
    chk("t3_drained", 128'(idx_count), 128'd0);
    tick();
    chk("t3_idle", 128'(out_valid), 128'd0);

    // Backpressure holds a beat stable
    idx_valid = 1'b1; idx_in = 2'd1; tick();
    idx_in = 2'd3; tick();
    idx_in = 2'd0; tick();
    idx_valid = 1'b0;
    out_ready = 1'b0; val_valid = 1'b1; val_in = 32'd100;
    tick();
    val_in = 32'd200;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t4_val_ready_low", 128'(val_ready), 128'd0);
      tick();
      chk("t4_hold_valid", 128'(out_valid), 128'd1);
      chk("t4_hold_data", out_data, lane(1, 32'd100));
      chk("t4_count", 128'(idx_count), 128'd2);
    end
    out_ready = 1'b1;
    settle();
    chk("t4_release_ready", 128'(val_ready), 128'd1);
    tick();
    chk("t4_second", out_data, lane(3, 32'd200));
    val_in = 32'd300;
    tick();
    chk("t4_third", out_data, lane(0, 32'd300));
    val_valid = 1'b0;
    tick();
    chk("t4_empty", 128'(idx_count), 128'd0);
    chk("t4_idle", 128'(out_valid), 128'd0);

    // Simultaneous push and pop at occupancy 7, crossing the pointer wrap
    q.delete();
    for (int i = 0; i < 7; i++) begin
      idx_valid = 1'b1; idx_in = 2'((i * 3) % 4);
      q.push_back((i * 3) % 4);
      tick();
    end
    chk("t5_pre", 128'(idx_count), 128'd7);
    val_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      idx_in = 2'((k + 1) % 4);
      val_in = 32'(1000 + k);
      tick();
      exp_data = lane(q.pop_front(), 32'(1000 + k));
      q.push_back((k + 1) % 4);
      chk("t5_count", 128'(idx_count), 128'd7);
      chk("t5_data", out_data, exp_data);
    end
    idx_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      val_in = 32'(2000 + k);
      tick();
      exp_data = lane(q.pop_front(), 32'(2000 + k));
      chk("t5_drain", out_data, exp_data);
    end
    val_valid = 1'b0;
    chk("t5_empty", 128'(idx_count), 128'd0);

    // Asynchronous reset mid-stream discards stored indices and the pending beat
    idx_valid = 1'b1; idx_in = 2'd2; tick();
    idx_valid = 1'b0;
    out_ready = 1'b0; val_valid = 1'b1; val_in = 32'hDEAD_BEEF; tick();
    val_valid = 1'b0;
    idx_valid = 1'b1; idx_in = 2'd1; tick();
    idx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_out_data", out_data, 128'd0);
    chk("arst_count", 128'(idx_count), 128'd0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    settle();
    chk("arst_idx_ready", 128'(idx_ready), 128'd1);
    chk("arst_val_ready", 128'(val_ready), 128'd0);

`ifdef MAX_UNPOOL_STATS_EN
    chk("st_count_rst", 128'(out_count), 128'd0);
    chk("st_underrun_rst", 128'(underrun), 128'd0);
    val_valid = 1'b1; val_in = 32'd7;
    tick();
    val_valid = 1'b0;
    chk("st_underrun_set", 128'(underrun), 128'd1);
    for (int i = 0; i < 3; i++) begin
      idx_valid = 1'b1; idx_in = 2'(i);
      tick();
    end
    idx_valid = 1'b0;
    chk("st_underrun_sticky", 128'(underrun), 128'd1);
    val_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      val_in = 32'(50 + i);
      tick();
    end
    val_valid = 1'b0;
    tick();
    chk("st_out_count", 128'(out_count), 128'd3);
    chk("st_underrun_held", 128'(underrun), 128'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
